// File: rtl/arm_alu_pkg.sv
// Shared ALU definitions for the ARM_64 execute path: datapath widths,
// NZCV flag layout and the add/subtract select encoding.
package arm_alu_pkg;

  localparam int DATA_W    = 64;
  localparam int CLA_SLICE = 16;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

endpackage

// File: rtl/arm_addsub_flags_pipe_if.sv
// Request/response bundle for the pipelined add/sub unit. The master side
// offers operations and consumes results; the slave side is the pipeline.
interface arm_addsub_flags_pipe_if
  import arm_alu_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic             op_sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_n;
  logic             flag_z;
  logic             flag_c;
  logic             flag_v;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, op_sub, a, b, carry_in, in_tag, out_ready,
    input  in_ready, out_valid, result, flag_n, flag_z, flag_c, flag_v, out_tag
  );

  modport slave (
    input  in_valid, op_sub, a, b, carry_in, in_tag, out_ready,
    output in_ready, out_valid, result, flag_n, flag_z, flag_c, flag_v, out_tag
  );
endinterface

// File: rtl/cla_slice.sv
// Combinational W-bit carry-lookahead slice built from 4-bit groups.
// Exposes slice-level generate/propagate so callers can look ahead further.
module cla_slice #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         g,
  output logic         p
);
  localparam int NG = W / 4;

  logic [W-1:0]  gb, pb, cb;
  logic [NG-1:0] gg, gp;
  logic [NG:0]   gc;
  logic          c;

  // bit G/P -> group G/P -> group carries -> bit carries -> sum
  always_comb begin
    gb = a & b;
    pb = a ^ b;
    gg = '0;
    gp = '1;
    gc = '0;
    cb = '0;
    c  = 1'b0;
    g  = 1'b0;
    p  = 1'b1;
    for (int j = 0; j < NG; j++) begin
      for (int i = 0; i < 4; i++) begin
        gg[j] = gb[4*j+i] | (pb[4*j+i] & gg[j]);
        gp[j] = gp[j] & pb[4*j+i];
      end
    end
    gc[0] = cin;
    for (int j = 0; j < NG; j++)
      gc[j+1] = gg[j] | (gp[j] & gc[j]);
    for (int j = 0; j < NG; j++) begin
      c = gc[j];
      for (int i = 0; i < 4; i++) begin
        cb[4*j+i] = c;
        c = gb[4*j+i] | (pb[4*j+i] & c);
      end
    end
    sum = pb ^ cb;
    for (int j = 0; j < NG; j++) begin
      g = gg[j] | (gp[j] & g);
      p = p & gp[j];
    end
    cout = g | (p & cin);
  end
endmodule

// File: rtl/arm_addsub_flags_pipe.sv
// Pipelined WIDTH-bit add/subtract with ARM NZCV flags. One SLICE-bit CLA
// slice is resolved per stage; the carry and running zero flag are
// registered between stages. Stage k's slice is combinational off its own
// registers, so the last stage drives the outputs directly.
// WIDTH must be a multiple of SLICE, and SLICE a multiple of 4.
module arm_addsub_flags_pipe
  import arm_alu_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int SLICE = CLA_SLICE,
  parameter int TAG_W = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  arm_addsub_flags_pipe_if.slave  io
);
  localparam int STAGES = WIDTH / SLICE;
  localparam int L      = STAGES - 1;

  logic [STAGES-1:0]                 vld_pipe, rdy, c_q, z_q;
  logic [STAGES-1:0][WIDTH-1:0]      a_q, b_q, r_q;
  logic [STAGES-1:0][TAG_W-1:0]      tag_q;
  logic [STAGES-1:0][SLICE-1:0]      slc_sum;
  logic [STAGES-1:0]                 slc_cout, slc_g, slc_p;
  logic [WIDTH-1:0]                  res_full;
  nzcv_t                             fl;
  logic                              unused_bits;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    cla_slice #(.W(SLICE)) u_cla (
      .a    (a_q[k][k*SLICE +: SLICE]),
      .b    (b_q[k][k*SLICE +: SLICE]),
      .cin  (c_q[k]),
      .sum  (slc_sum[k]),
      .cout (slc_cout[k]),
      .g    (slc_g[k]),
      .p    (slc_p[k])
    );
  end

  // ready ripples back from the consumer; an empty stage is always ready
  always_comb begin
    rdy    = '0;
    rdy[L] = !vld_pipe[L] | io.out_ready;
    for (int k = L - 1; k >= 0; k--)
      rdy[k] = !vld_pipe[k] | rdy[k+1];
  end

  // stage registers: stage 0 captures operands, later stages take the
  // previous stage plus its freshly resolved slice; stalled stages hold
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      c_q      <= '0;
      z_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      tag_q    <= '0;
    end else begin
      if (rdy[0]) begin
        vld_pipe[0] <= io.in_valid;
        a_q[0]      <= io.a;
        b_q[0]      <= (io.op_sub == OP_SUB) ? ~io.b : io.b;
        r_q[0]      <= '0;
        c_q[0]      <= io.carry_in;
        z_q[0]      <= 1'b1;
        tag_q[0]    <= io.in_tag;
      end
      for (int k = 1; k < STAGES; k++) begin
        if (rdy[k]) begin
          vld_pipe[k] <= vld_pipe[k-1];
          a_q[k]      <= a_q[k-1];
          b_q[k]      <= b_q[k-1];
          r_q[k]      <= r_q[k-1];
          r_q[k][(k-1)*SLICE +: SLICE] <= slc_sum[k-1];
          c_q[k]      <= slc_cout[k-1];
          z_q[k]      <= z_q[k-1] & ~|slc_sum[k-1];
          tag_q[k]    <= tag_q[k-1];
        end
      end
    end
  end

  // final result and NZCV from the last stage's top slice
  always_comb begin
    res_full = r_q[L];
    res_full[L*SLICE +: SLICE] = slc_sum[L];
    fl.n = res_full[WIDTH-1];
    fl.z = z_q[L] & ~|slc_sum[L];
    fl.c = slc_cout[L];
    fl.v = (a_q[L][WIDTH-1] == b_q[L][WIDTH-1]) &
           (res_full[WIDTH-1] != a_q[L][WIDTH-1]);
  end

  assign io.in_ready  = rdy[0];
  assign io.out_valid = vld_pipe[L];
  assign io.result    = vld_pipe[L] ? res_full : '0;
  assign io.flag_n    = vld_pipe[L] & fl.n;
  assign io.flag_z    = vld_pipe[L] & fl.z;
  assign io.flag_c    = vld_pipe[L] & fl.c;
  assign io.flag_v    = vld_pipe[L] & fl.v;
  assign io.out_tag   = vld_pipe[L] ? tag_q[L] : '0;

  // slice G/P and the already-consumed low bits of the last stage have no reader
  assign unused_bits = ^{slc_g, slc_p, a_q[L], b_q[L], r_q[L]};
endmodule

// File: tb/tb_arm_addsub_flags_pipe.sv
// Bench for arm_addsub_flags_pipe: directed vectors with literal expectations,
// plus a queue-based arithmetic model checked on every output transfer.
module tb_arm_addsub_flags_pipe;
  import arm_alu_pkg::*;

  localparam int W   = 64;
  localparam int TW  = 4;
  localparam int STG = 4;

  typedef struct {
    logic [W-1:0]  res;
    logic [3:0]    nzcv;
    logic [TW-1:0] tag;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  arm_addsub_flags_pipe_if #(.WIDTH(W), .TAG_W(TW)) bus ();

  arm_addsub_flags_pipe #(.WIDTH(W), .SLICE(16), .TAG_W(TW)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  int            checks = 0;
  int            errors = 0;
  int            n_out  = 0;
  exp_t          q[$];
  exp_t          mon_e;
  logic [W-1:0]  last_res;
  logic [3:0]    last_nzcv;
  logic [TW-1:0] last_tag;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // sum as a 65-bit unsigned add; overflow from true signed arithmetic
  function automatic exp_t model(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic [TW-1:0] tag);
    exp_t         e;
    logic [W-1:0] op2;
    logic [W:0]   s;
    logic [W+1:0] ss;
    op2 = (sub == OP_SUB) ? ~b : b;
    s   = {1'b0, a} + {1'b0, op2} + {{W{1'b0}}, cin};
    ss  = $signed({{2{a[W-1]}}, a}) + $signed({{2{op2[W-1]}}, op2}) + {{(W+1){1'b0}}, cin};
    e.res  = s[W-1:0];
    e.nzcv = {s[W-1], (s[W-1:0] == '0), s[W], (ss[W+1] != ss[W-1])};
    e.tag  = tag;
    return e;
  endfunction

  // per-cycle scoreboard: ready rule, output transfers, accepted operations
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
    end else begin
      chk("in_ready_rule", 64'(bus.in_ready), 64'(!(q.size() == STG && !bus.out_ready)));
      if (bus.out_valid && q.size() == 0) begin
        chk("spurious_out_valid", 64'(bus.out_valid), 64'd0);
      end else if (bus.out_valid && bus.out_ready) begin
        mon_e = q.pop_front();
        chk("model_result", bus.result, mon_e.res);
        chk("model_nzcv", 64'({bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v}), 64'(mon_e.nzcv));
        chk("model_tag", 64'(bus.out_tag), 64'(mon_e.tag));
        last_res  = bus.result;
        last_nzcv = {bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v};
        last_tag  = bus.out_tag;
        n_out++;
      end
      if (bus.in_valid && bus.in_ready)
        q.push_back(model(bus.op_sub, bus.a, bus.b, bus.carry_in, bus.in_tag));
    end
  end

  task automatic send(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic [TW-1:0] tag);
    int i;
    bus.in_valid = 1'b1;
    bus.op_sub   = sub;
    bus.a        = a;
    bus.b        = b;
    bus.carry_in = cin;
    bus.in_tag   = tag;
    for (i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.in_ready) break;
    end
    if (i == 40) chk("accept_timeout", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input int tgt);
    for (int i = 0; i < 40 && n_out < tgt; i++) begin
      @(posedge clk); #1;
    end
    chk("drain_count", 64'(n_out), 64'(tgt));
  endtask

  task automatic op_lit(input string name, input logic sub, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic cin, input logic [TW-1:0] tag,
                        input logic [W-1:0] xres, input logic [3:0] xnzcv);
    int tgt;
    tgt = n_out + 1;
    send(sub, a, b, cin, tag);
    idle();
    wait_out(tgt);
    chk({name, "_res"}, last_res, xres);
    chk({name, "_nzcv"}, 64'(last_nzcv), 64'(xnzcv));
    chk({name, "_tag"}, 64'(last_tag), 64'(tag));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  logic saw_full;
  int   tgt;

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op_sub    = OP_ADD;
    bus.a         = '0;
    bus.b         = '0;
    bus.carry_in  = 1'b0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_result", bus.result, 64'd0);
    chk("rst_flags", 64'({bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v}), 64'd0);
    chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
    reset = 1'b0;

    // latency: accepted at edge t, out_valid visible after edge t+3
    tgt = n_out + 1;
    send(OP_SUB, 64'd5, 64'd3, 1'b1, 4'd1);
    idle();
    chk("lat_t0", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1; chk("lat_t1", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1; chk("lat_t2", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1; chk("lat_t3", 64'(bus.out_valid), 64'd1);
    wait_out(tgt);
    chk("sub5_3_res", last_res, 64'd2);
    chk("sub5_3_nzcv", 64'(last_nzcv), 64'b0010);
    chk("sub5_3_tag", 64'(last_tag), 64'd1);

    op_lit("sub3_5", OP_SUB, 64'd3, 64'd5, 1'b1, 4'd2, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000);
    op_lit("add_ovf", OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 4'd3,
           64'h8000_0000_0000_0000, 4'b1001);
    op_lit("sub_ovf", OP_SUB, 64'h8000_0000_0000_0000, 64'd1, 1'b1, 4'd4,
           64'h7FFF_FFFF_FFFF_FFFF, 4'b0011);
    op_lit("add_ripple", OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 4'd5, 64'd0, 4'b0110);
    op_lit("add_slice_cy", OP_ADD, 64'h0000_FFFF_FFFF_0000, 64'h0000_0000_0001_0000, 1'b0,
           4'd6, 64'h0001_0000_0000_0000, 4'b0000);
    op_lit("sbc_nocin", OP_SUB, 64'd5, 64'd3, 1'b0, 4'd7, 64'd1, 4'b0010);

    // backpressure: six back-to-back ops, consumer stalls for cycles 2..6
    tgt      = n_out + 6;
    saw_full = 1'b0;
    fork
      begin
        for (int t = 0; t < 6; t++)
          send(1'(t % 2), 64'd1000 + 64'(t * 77), 64'(t * 300), 1'(t % 2), 4'(t));
        idle();
      end
      begin
        bus.out_ready = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        bus.out_ready = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        bus.out_ready = 1'b1;
      end
      begin
        repeat (12) begin
          @(negedge clk);
          if (!bus.in_ready) saw_full = 1'b1;
        end
      end
    join
    wait_out(tgt);
    chk("bp_in_ready_fell", 64'(saw_full), 64'd1);
    chk("bp_queue_empty", 64'(q.size()), 64'd0);

    // random operands under random consumer stalls, checked by the model
    tgt = n_out + 8;
    fork
      begin
        for (int t = 0; t < 8; t++)
          send(1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
               1'($urandom_range(0, 1)), 4'(t + 8));
        idle();
      end
      begin
        for (int t = 0; t < 30; t++) begin
          bus.out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    wait_out(tgt);

    // reset with three operations in flight: none of them may emerge
    tgt = n_out;
    send(OP_ADD, 64'd11, 64'd22, 1'b0, 4'd7);
    send(OP_ADD, 64'd33, 64'd44, 1'b0, 4'd8);
    send(OP_SUB, 64'd55, 64'd66, 1'b1, 4'd9);
    idle();
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_mid_result", bus.result, 64'd0);
    reset = 1'b0;
    for (int t = 0; t < 4; t++) begin
      @(posedge clk); #1;
      chk("rst_discard_valid", 64'(bus.out_valid), 64'd0);
    end
    chk("rst_discard_count", 64'(n_out), 64'(tgt));
    op_lit("sub10_4", OP_SUB, 64'd10, 64'd4, 1'b1, 4'd3, 64'd6, 4'b0010);

    chk("final_queue_empty", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
